stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Sequencing controller for the lab stopwatch: owns the minute/second registers that feed the seven-segment driver and decides when they count, pause, clear or are manually adjusted. Sits between the debounced button/switch inputs and the display driver's `min`/`sec` inputs. It derives a 1 Hz count tick and a 2 Hz adjust tick from the system clock and, optionally, blink-blanking flags for the field being adjusted.

## Interface
- `TICKS_PER_SEC`, default 100_000_000: clk cycles per counted second; must be at least 2.
- `ADJ_TICKS`, default 50_000_000: clk cycles per adjust increment; must be even and at least 2.
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `pause_p` in 1: single-cycle pulse from the debouncer; toggles run/pause.
- `clr_p` in 1: single-cycle pulse; clears time to 00:00.
- `adj_en` in 1: level; high selects adjust mode.
- `adj_sel` in 1: level; 0 adjusts minutes, 1 adjusts seconds.
- `min` out 6: minutes, 0–59, registered.
- `sec` out 6: seconds, 0–59, registered.
- `running` out 1: high in RUN, registered.
- `blank_min` out 1: blank the minute digits this cycle, registered.
- `blank_sec` out 1: blank the second digits this cycle, registered.

## Operation
- States: RUN, PAUSED, ADJUST.
- Reset values:
  - State: RUN.
  - `min`, `sec`: 0.
  - `running`: 1.
  - `blank_*`: 0.
  - Both prescalers: 0.
- Input priority within one cycle: `rst_n` > `clr_p` > `adj_en` > `pause_p`.
- `clr_p`: `min`/`sec` and both prescalers go to 0; the state is unchanged. A count or adjust tick in the same cycle is discarded.
- `adj_en` high from RUN or PAUSED: go to ADJUST and clear the adjust prescaler.
- `adj_en` low in ADJUST: go to PAUSED.
- `pause_p` has the following effect, and is ignored in ADJUST:
  - RUN goes to PAUSED.
  - PAUSED goes to RUN.
- RUN:
  - The second prescaler counts from 0 to `TICKS_PER_SEC`-1.
  - At the terminal count it wraps to 0 and `sec` increments.
  - `sec` 59 wraps to 0 and carries into `min`.
  - `min` 59 with a carry wraps to 0, so 59:59 becomes 00:00.
- PAUSED and ADJUST: the second prescaler holds its value, so the sub-second fraction survives a pause.
- ADJUST:
  - The adjust prescaler counts from 0 to `ADJ_TICKS`-1 and wraps.
  - On each wrap the field chosen by `adj_sel` increments by 1, wrapping 59 to 0.
  - There is no carry between fields.
  - Changing `adj_sel` mid-period does not reset the prescaler.
- Arithmetic uses 6-bit fields, and no value above 59 is ever produced.

## Timing
- After `rst_n` is released, the first `sec` increment is visible `TICKS_PER_SEC` cycles later.
- Every output is registered. An input sampled on edge N is reflected in the outputs after edge N.
- `running` changes on the same edge as the state.
- After entering ADJUST, the first increment lands `ADJ_TICKS` cycles later.
- After PAUSED returns to RUN, the next increment lands after the remaining (`TICKS_PER_SEC` − held count) cycles.
- `clr_p` and `pause_p` arriving in the same cycle: both take effect (clear and toggle), because clear does not change state.

## Configuration
- `STOPWATCH_BLINK_EN` defined:
  - In ADJUST, the selected field's `blank_*` is 1 while the adjust prescaler is below `ADJ_TICKS`/2 and 0 otherwise.
  - The unselected field's flag is 0.
  - Both flags are 0 outside ADJUST.
- `STOPWATCH_BLINK_EN` undefined: `blank_min` and `blank_sec` are tied to 0, and no blink logic is generated.

## Structure
- Package `stopwatch_pkg`:
  - State encoding for RUN, PAUSED and ADJUST.
  - `MAX_FIELD` = 59.
  - Field width constant = 6.
- Sub-module `tick_gen`:
  - Parameter: `DIV`.
  - Ports: `clk`, `rst_n`, `en`, `clr`, `cnt`, `tick`.
  - Instantiated twice, once for seconds and once for adjust.
  - `tick` is combinational on the terminal count while `en` is high.
- The FSM and the field counters live in `stopwatch_ctrl`.

## Test plan
All scenarios use `TICKS_PER_SEC`=4 and `ADJ_TICKS`=4.
- Reset, then run 16 cycles → `sec` steps 1, 2, 3, 4 on cycles 4, 8, 12, 16; `running`=1.
- Preload 00:59 via adjust, return to RUN and run 4 cycles → 01:00. Preload 59:59 and run 4 cycles → 00:00.
- RUN 2 cycles, `pause_p`, wait 20 cycles → `sec` unchanged. Then `pause_p` → `sec` increments exactly 2 cycles after resume.
- `adj_en`=1 with `adj_sel`=1 from sec=58 for 8 cycles → 59, then 0, and `min` unchanged. `adj_en`=0 → PAUSED with `running`=0.
- `clr_p` at 12:34 together with `pause_p` in RUN → 00:00, state PAUSED, and no increment on that cycle.
- With `STOPWATCH_BLINK_EN`, in ADJUST with `adj_sel`=0 → `blank_min`=1 for 2 cycles then 0 for 2 cycles; `blank_sec`=0 throughout. Without the macro, both flags stay 0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared definitions for the stopwatch controller.
//   state_e   : controller state encoding (RUN, PAUSED, ADJUST)
//   FIELD_W   : width of the minute and second fields
//   MAX_FIELD : largest value either field may hold
//   field_inc : modulo-60 increment of one field
package stopwatch_pkg;

    localparam int FIELD_W = 6;
    localparam logic [FIELD_W-1:0] MAX_FIELD = 6'd59;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ADJUST = 2'd2
    } state_e;

    // Anything at or above 59 wraps to 0, so an out-of-range value can
    // never be propagated further.
    function automatic logic [FIELD_W-1:0] field_inc(input logic [FIELD_W-1:0] v);
        return (v >= MAX_FIELD) ? '0 : v + FIELD_W'(1);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen
// Modulo-DIV prescaler producing a one-cycle tick on its terminal count.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   en    : count enable; the count holds while low
//   clr   : synchronous clear to 0, overrides en
//   cnt   : current prescaler count, 0 .. DIV-1
//   tick  : combinational, high while en is high and cnt is DIV-1
module tick_gen #(
    parameter int DIV = 4,
    localparam int CW = $clog2(DIV)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          tick
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == CW'(DIV - 1));
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// Run/pause/adjust sequencer owning the minute and second registers that
// feed the seven-segment driver.
//   clk        : system clock
//   rst_n      : synchronous active-low reset
//   pause_p    : one-cycle pulse, toggles RUN/PAUSED (ignored in ADJUST)
//   clr_p      : one-cycle pulse, clears time and both prescalers
//   adj_en     : level, selects ADJUST mode
//   adj_sel    : level, 0 adjusts minutes, 1 adjusts seconds
//   min, sec   : registered time fields, 0..59
//   running    : registered, high in RUN
//   blank_min  : registered blink flag for the minute digits
//   blank_sec  : registered blink flag for the second digits
// Build option: STOPWATCH_BLINK_EN enables the adjust blink flags; without
// it both flags are tied low.
//
// state     | meaning
// ----------+---------------------------------------------------
// ST_RUN    | second prescaler counting, time advances at 1 Hz
// ST_PAUSED | time and second prescaler frozen
// ST_ADJUST | selected field steps once per ADJ_TICKS cycles
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int ADJ_TICKS     = 50_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pause_p,
    input  logic               clr_p,
    input  logic               adj_en,
    input  logic               adj_sel,
    output logic [FIELD_W-1:0] min,
    output logic [FIELD_W-1:0] sec,
    output logic               running,
    output logic               blank_min,
    output logic               blank_sec
);

    localparam int SEC_W = $clog2(TICKS_PER_SEC);
    localparam int ADJ_W = $clog2(ADJ_TICKS);

    state_e             state_q, state_d;
    logic [FIELD_W-1:0] min_q, min_d;
    logic [FIELD_W-1:0] sec_q, sec_d;
    logic               running_q;

    logic [SEC_W-1:0]   sec_cnt;
    logic [ADJ_W-1:0]   adj_cnt;
    logic               sec_tick;
    logic               adj_tick;
    logic               adj_clr;

    // Entering ADJUST restarts the adjust period so the first step lands a
    // full ADJ_TICKS after entry.
    assign adj_clr = clr_p || (adj_en && (state_q != ST_ADJUST));

    tick_gen #(.DIV(TICKS_PER_SEC)) u_sec_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == ST_RUN),
        .clr   (clr_p),
        .cnt   (sec_cnt),
        .tick  (sec_tick)
    );

    tick_gen #(.DIV(ADJ_TICKS)) u_adj_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == ST_ADJUST),
        .clr   (adj_clr),
        .cnt   (adj_cnt),
        .tick  (adj_tick)
    );

    // The seconds prescaler count is only needed for debug visibility.
    logic unused_sec_cnt;
    assign unused_sec_cnt = ^sec_cnt;

    always_comb begin
        state_d = state_q;
        if (adj_en) begin
            state_d = ST_ADJUST;
        end else begin
            case (state_q)
                ST_ADJUST: state_d = ST_PAUSED;
                ST_RUN:    if (pause_p) state_d = ST_PAUSED;
                ST_PAUSED: if (pause_p) state_d = ST_RUN;
                default:   state_d = ST_RUN;
            endcase
        end
    end

    // Ticks are decided by the current state; a clear discards them.
    always_comb begin
        min_d = min_q;
        sec_d = sec_q;
        if (clr_p) begin
            min_d = '0;
            sec_d = '0;
        end else if (sec_tick) begin
            sec_d = field_inc(sec_q);
            if (sec_q >= MAX_FIELD) begin
                min_d = field_inc(min_q);
            end
        end else if (adj_tick) begin
            if (adj_sel) begin
                sec_d = field_inc(sec_q);
            end else begin
                min_d = field_inc(min_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            min_q     <= '0;
            sec_q     <= '0;
            running_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            running_q <= (state_d == ST_RUN);
        end
    end

    assign min     = min_q;
    assign sec     = sec_q;
    assign running = running_q;

`ifdef STOPWATCH_BLINK_EN
    logic [ADJ_W-1:0] adj_cnt_nxt;
    logic             blink_on;
    logic             blank_min_q, blank_min_d;
    logic             blank_sec_q, blank_sec_d;

    // Flags are registered against the prescaler value that will be live
    // in the same cycle, so blanking lines up with the adjust period.
    always_comb begin
        adj_cnt_nxt = adj_cnt;
        if (adj_clr || adj_tick) begin
            adj_cnt_nxt = '0;
        end else if (state_q == ST_ADJUST) begin
            adj_cnt_nxt = adj_cnt + ADJ_W'(1);
        end
        blink_on    = (state_d == ST_ADJUST) && (adj_cnt_nxt < ADJ_W'(ADJ_TICKS / 2));
        blank_min_d = blink_on && !adj_sel;
        blank_sec_d = blink_on && adj_sel;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blank_min_q <= 1'b0;
            blank_sec_q <= 1'b0;
        end else begin
            blank_min_q <= blank_min_d;
            blank_sec_q <= blank_sec_d;
        end
    end

    assign blank_min = blank_min_q;
    assign blank_sec = blank_sec_q;
`else
    logic unused_adj_cnt;
    assign unused_adj_cnt = ^adj_cnt;
    assign blank_min      = 1'b0;
    assign blank_sec      = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
// Directed bench for stopwatch_ctrl with TICKS_PER_SEC = ADJ_TICKS = 4.
// A behavioural model tracks time as plain integers and is compared with
// the DUT on every falling edge; literal checks pin the model at key points.
module tb_stopwatch_ctrl;

    localparam int T = 4;
    localparam int A = 4;

`ifdef STOPWATCH_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    localparam int M_RUN = 0;
    localparam int M_PAUSED = 1;
    localparam int M_ADJUST = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pause_p = 1'b0;
    logic       clr_p = 1'b0;
    logic       adj_en = 1'b0;
    logic       adj_sel = 1'b0;
    logic [5:0] min;
    logic [5:0] sec;
    logic       running;
    logic       blank_min;
    logic       blank_sec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.TICKS_PER_SEC(T), .ADJ_TICKS(A)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pause_p   (pause_p),
        .clr_p     (clr_p),
        .adj_en    (adj_en),
        .adj_sel   (adj_sel),
        .min       (min),
        .sec       (sec),
        .running   (running),
        .blank_min (blank_min),
        .blank_sec (blank_sec)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: elapsed time in seconds, fractional counters as ints.
    bit m_valid = 1'b0;
    int m_mode = M_RUN;
    int m_min = 0;
    int m_sec = 0;
    int m_ps = 0;
    int m_pa = 0;
    bit m_bmin = 1'b0;
    bit m_bsec = 1'b0;

    always @(posedge clk) begin : model
        bit ts;
        bit ta;
        int total;
        if (!rst_n) begin
            m_valid = 1'b1;
            m_mode = M_RUN;
            m_min = 0;
            m_sec = 0;
            m_ps = 0;
            m_pa = 0;
        end else begin
            ts = (m_mode == M_RUN) && (m_ps == T - 1);
            ta = (m_mode == M_ADJUST) && (m_pa == A - 1);
            if (clr_p) m_ps = 0;
            else if (m_mode == M_RUN) m_ps = (m_ps + 1) % T;
            if (clr_p || (adj_en && m_mode != M_ADJUST)) m_pa = 0;
            else if (m_mode == M_ADJUST) m_pa = (m_pa + 1) % A;
            if (clr_p) begin
                m_min = 0;
                m_sec = 0;
            end else if (ts) begin
                total = (m_min * 60 + m_sec + 1) % 3600;
                m_min = total / 60;
                m_sec = total % 60;
            end else if (ta) begin
                if (adj_sel) m_sec = (m_sec + 1) % 60;
                else m_min = (m_min + 1) % 60;
            end
            if (adj_en) m_mode = M_ADJUST;
            else if (m_mode == M_ADJUST) m_mode = M_PAUSED;
            else if (pause_p) m_mode = (m_mode == M_RUN) ? M_PAUSED : M_RUN;
        end
        m_bmin = BLINK && (m_mode == M_ADJUST) && !adj_sel && (m_pa < A / 2);
        m_bsec = BLINK && (m_mode == M_ADJUST) && adj_sel && (m_pa < A / 2);
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_min", min, m_min);
            chk("model_sec", sec, m_sec);
            chk("model_running", running, (m_mode == M_RUN));
            chk("model_blank_min", blank_min, m_bmin);
            chk("model_blank_sec", blank_sec, m_bsec);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_pause();
        pause_p = 1'b1;
        step(1);
        pause_p = 1'b0;
    endtask

    initial begin
        // Reset state
        step(2);
        chk("rst_min", min, 0);
        chk("rst_sec", sec, 0);
        chk("rst_running", running, 1);
        chk("rst_blank_min", blank_min, 0);
        chk("rst_blank_sec", blank_sec, 0);
        rst_n = 1'b1;

        // Free run: one second every T cycles
        for (int k = 1; k <= 4; k++) begin
            step(T - 1);
            chk("run_sec_before", sec, k - 1);
            step(1);
            chk("run_sec", sec, k);
        end
        chk("run_running", running, 1);

        // Preload 00:59, resume, carry into minutes
        clr_p = 1'b1; adj_en = 1'b1; adj_sel = 1'b1;
        step(1);
        clr_p = 1'b0;
        step(59 * A);
        chk("pre59_sec", sec, 59);
        chk("pre59_min", min, 0);
        chk("adj_running", running, 0);
        adj_en = 1'b0;
        step(1);
        pulse_pause();
        step(T - 1);
        chk("carry_hold_sec", sec, 59);
        step(1);
        chk("carry_min", min, 1);
        chk("carry_sec", sec, 0);

        // Preload 59:59, full wrap to 00:00
        clr_p = 1'b1; adj_en = 1'b1; adj_sel = 1'b0;
        step(1);
        clr_p = 1'b0;
        step(59 * A);
        adj_sel = 1'b1;
        step(59 * A);
        chk("pre5959_min", min, 59);
        chk("pre5959_sec", sec, 59);
        adj_en = 1'b0;
        step(1);
        pulse_pause();
        step(T);
        chk("wrap_min", min, 0);
        chk("wrap_sec", sec, 0);

        // Pause keeps the sub-second fraction
        step(1);
        pulse_pause();
        step(20);
        chk("pause_sec", sec, 0);
        chk("pause_running", running, 0);
        pulse_pause();
        chk("resume_running", running, 1);
        step(1);
        chk("resume_sec_early", sec, 0);
        step(1);
        chk("resume_sec", sec, 1);

        // Adjust seconds from 58, no carry into minutes
        clr_p = 1'b1; adj_en = 1'b1; adj_sel = 1'b1;
        step(1);
        clr_p = 1'b0;
        step(58 * A);
        chk("adj58_sec", sec, 58);
        step(A);
        chk("adj59_sec", sec, 59);
        step(A);
        chk("adjwrap_sec", sec, 0);
        chk("adjwrap_min", min, 0);
        adj_en = 1'b0;
        step(1);
        chk("adj_exit_running", running, 0);

        // Clear together with pause at 12:34, on a would-be tick cycle
        clr_p = 1'b1; adj_en = 1'b1; adj_sel = 1'b0;
        step(1);
        clr_p = 1'b0;
        step(12 * A);
        adj_sel = 1'b1;
        step(34 * A);
        chk("pre1234_min", min, 12);
        chk("pre1234_sec", sec, 34);
        adj_en = 1'b0;
        step(1);
        pulse_pause();
        step(T - 1);
        clr_p = 1'b1; pause_p = 1'b1;
        step(1);
        clr_p = 1'b0; pause_p = 1'b0;
        chk("clr_min", min, 0);
        chk("clr_sec", sec, 0);
        chk("clr_running", running, 0);
        step(T);
        chk("clr_hold_sec", sec, 0);

        // Blink flags in ADJUST with minutes selected
        adj_en = 1'b1; adj_sel = 1'b0;
        for (int i = 0; i < A; i++) begin
            step(1);
            chk("blink_min", blank_min, (BLINK && i < A / 2));
            chk("blink_sec", blank_sec, 0);
        end
        adj_en = 1'b0;
        step(1);
        chk("blink_off_min", blank_min, 0);

        // Reset mid-operation
        rst_n = 1'b0;
        step(1);
        chk("rst2_min", min, 0);
        chk("rst2_running", running, 1);
        rst_n = 1'b1;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
